// File: rtl/can_bit_timing.sv
// CAN bit-timing generator: runtime prescaler, SYNC/TSEG1/TSEG2 sequencing,
// hard synchronisation and SJW-limited resynchronisation.
module can_bit_timing #(
  parameter int BRP_W   = 8,
  parameter int TSEG1_W = 5,
  parameter int TSEG2_W = 4,
  parameter int SJW_W   = 2
) (
  input  logic               clock_in_i,
  input  logic               reset_ni,
  input  logic               en_i,
  input  logic [BRP_W-1:0]   brp_i,
  input  logic [TSEG1_W-1:0] tseg1_i,
  input  logic [TSEG2_W-1:0] tseg2_i,
  input  logic [SJW_W-1:0]   sjw_i,
  input  logic               hard_sync_i,
  input  logic               rx_edge_i,
  output logic               tq_tick_o,
  output logic               sample_pulse_o,
  output logic               bit_start_o,
  output logic [1:0]         seg_o,
  output logic               cfg_err_o
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SYNC  = 2'd1;
  localparam logic [1:0] TSEG1 = 2'd2;
  localparam logic [1:0] TSEG2 = 2'd3;

  localparam int S1W = TSEG1_W + 1;
  localparam int XW  = TSEG2_W + 1;
  localparam int CW  = (S1W > XW) ? S1W : XW;

  logic [1:0]         seg;
  logic [BRP_W-1:0]   pre_cnt, brp_q;
  logic [CW-1:0]      seg_cnt;
  logic [TSEG1_W-1:0] tseg1_q;
  logic [TSEG2_W-1:0] tseg2_q;
  logic [SJW_W-1:0]   sjw_q;
  logic [XW-1:0]      ext, shrink;
  logic               resynced, skip, bit_start, cfg_err;

  logic               running, tick, cfg_ok, edge_ok, late_edge;
  logic [CW-1:0]      sjw1, e_cnt, ext_new;
  logic [XW-1:0]      ext_eff, shrink_eff;
  logic               skip_eff;
  logic [S1W-1:0]     t1_end;
  logic [XW-1:0]      t2_end;
  logic               t1_done, t2_done;

  assign running = (seg != IDLE);
  assign tick    = running && (pre_cnt == brp_q);
  assign cfg_ok  = 32'(sjw_i) <= 32'(tseg2_i);

  // Hard sync takes priority, so a coincident edge is not consumed.
  assign edge_ok = rx_edge_i && running && !resynced && !hard_sync_i;

  assign sjw1    = CW'(sjw_q) + 1'b1;
  assign e_cnt   = seg_cnt + 1'b1;
  assign ext_new = (e_cnt < sjw1) ? e_cnt : sjw1;

  // Phase error in TSEG2 no larger than SJW: the edge tq becomes the new SYNC.
  assign late_edge = (32'(seg_cnt) + 32'(sjw_q)) >= 32'(tseg2_q);

  // Resync results are applied in the same clock so an edge on a tick
  // already moves that tick's segment boundary.
  assign ext_eff    = (edge_ok && seg == TSEG1) ? XW'(ext_new) : ext;
  assign shrink_eff = (edge_ok && seg == TSEG2 && !late_edge) ? XW'(sjw1) : shrink;
  assign skip_eff   = skip || (edge_ok && seg == TSEG2 && late_edge);

  assign t1_end  = S1W'(tseg1_q) + S1W'(ext_eff);
  assign t2_end  = XW'(tseg2_q) - shrink_eff;
  assign t1_done = tick && (seg == TSEG1) && (seg_cnt == CW'(t1_end));
  assign t2_done = tick && (seg == TSEG2) && (skip_eff || seg_cnt == CW'(t2_end));

  always_ff @(posedge clock_in_i or negedge reset_ni) begin
    if (!reset_ni) begin
      seg       <= IDLE;
      pre_cnt   <= '0;
      seg_cnt   <= '0;
      brp_q     <= '0;
      tseg1_q   <= '0;
      tseg2_q   <= '0;
      sjw_q     <= '0;
      ext       <= '0;
      shrink    <= '0;
      resynced  <= 1'b0;
      skip      <= 1'b0;
      bit_start <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      bit_start <= 1'b0;
      if (!en_i) begin
        seg      <= IDLE;
        pre_cnt  <= '0;
        seg_cnt  <= '0;
        ext      <= '0;
        shrink   <= '0;
        resynced <= 1'b0;
        skip     <= 1'b0;
        cfg_err  <= 1'b0;
      end else if (!running || hard_sync_i) begin
        // Start-up and hard sync share the config latch and counter clear.
        pre_cnt  <= '0;
        seg_cnt  <= '0;
        ext      <= '0;
        shrink   <= '0;
        resynced <= 1'b0;
        skip     <= 1'b0;
        cfg_err  <= !cfg_ok;
        if (cfg_ok) begin
          brp_q     <= brp_i;
          tseg1_q   <= tseg1_i;
          tseg2_q   <= tseg2_i;
          sjw_q     <= sjw_i;
          seg       <= running ? TSEG1 : SYNC;
          bit_start <= 1'b1;
        end else begin
          seg <= IDLE;
        end
      end else begin
        pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
        if (edge_ok) resynced <= 1'b1;
        ext    <= ext_eff;
        shrink <= shrink_eff;
        skip   <= skip_eff;
        if (tick) begin
          seg_cnt <= seg_cnt + 1'b1;
          case (seg)
            SYNC: begin
              seg     <= TSEG1;
              seg_cnt <= '0;
            end
            TSEG1: if (t1_done) begin
              seg     <= TSEG2;
              seg_cnt <= '0;
            end
            TSEG2: if (t2_done) begin
              seg       <= skip_eff ? TSEG1 : SYNC;
              seg_cnt   <= '0;
              bit_start <= 1'b1;
              resynced  <= 1'b0;
              ext       <= '0;
              shrink    <= '0;
              skip      <= 1'b0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign tq_tick_o      = tick;
  assign sample_pulse_o = t1_done;
  assign bit_start_o    = bit_start;
  assign seg_o          = seg;
  assign cfg_err_o      = cfg_err;
endmodule

// File: tb/tb_can_bit_timing.sv
// Directed bench for can_bit_timing; bit-start and sample-point cycles are
// queued as expectations and matched by a pulse monitor.
module tb_can_bit_timing;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] brp = '0;
  logic [4:0] tseg1 = '0;
  logic [3:0] tseg2 = '0;
  logic [1:0] sjw = '0;
  logic       hsync = 1'b0;
  logic       rx_edge = 1'b0;
  logic       tq_tick, sample_pulse, bit_start, cfg_err;
  logic [1:0] seg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bs_q[$];
  int smp_q[$];

  can_bit_timing dut (
    .clock_in_i(clk), .reset_ni(rst_n), .en_i(en),
    .brp_i(brp), .tseg1_i(tseg1), .tseg2_i(tseg2), .sjw_i(sjw),
    .hard_sync_i(hsync), .rx_edge_i(rx_edge),
    .tq_tick_o(tq_tick), .sample_pulse_o(sample_pulse), .bit_start_o(bit_start),
    .seg_o(seg), .cfg_err_o(cfg_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cyc %0d: observed %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic pulse_edge(input int t, input logic hs);
    wait_cyc(t);
    rx_edge = 1'b1;
    hsync   = hs;
    wait_cyc(t + 1);
    rx_edge = 1'b0;
    hsync   = 1'b0;
  endtask

  // Every pulse must match the head of its expectation queue (-1 = unexpected).
  always @(negedge clk) begin
    int exp;
    if (bit_start === 1'b1) begin
      exp = (bs_q.size() != 0) ? bs_q.pop_front() : -1;
      chk("bit_start_cycle", cyc, exp);
    end
    if (sample_pulse === 1'b1) begin
      exp = (smp_q.size() != 0) ? smp_q.pop_front() : -1;
      chk("sample_cycle", cyc, exp);
      chk("sample_with_tick", tq_tick, 1);
    end
  end

  initial begin #100000; $display("FAIL watchdog: simulation did not finish"); $fatal(1); end

  initial begin
    int bs_b[]  = '{5, 21, 37, 55, 75, 89, 99, 117, 131, 145};
    int smp_b[] = '{14, 30, 48, 68, 84, 96, 110, 126, 138};

    // Reset state
    #1;
    chk("rst_seg", seg, 0);
    chk("rst_tick", tq_tick, 0);
    chk("rst_sample", sample_pulse, 0);
    chk("rst_bit_start", bit_start, 0);
    chk("rst_cfg_err", cfg_err, 0);

    wait_cyc(2);
    rst_n = 1'b1;
    brp = 8'd1; tseg1 = 5'd3; tseg2 = 4'd2; sjw = 2'd1;
    foreach (bs_b[i]) bs_q.push_back(bs_b[i]);
    foreach (smp_b[i]) smp_q.push_back(smp_b[i]);
    wait_cyc(4);
    en = 1'b1;

    // Nominal bit
    wait_cyc(5);  chk("nom_sync", seg, 1); chk("nom_tick_p0", tq_tick, 0);
    wait_cyc(6);  chk("nom_sync2", seg, 1); chk("nom_tick_p1", tq_tick, 1);
    wait_cyc(7);  chk("nom_tseg1", seg, 2);
    wait_cyc(15); chk("nom_tseg2", seg, 3);
    wait_cyc(20); chk("nom_tseg2_end", seg, 3);
    wait_cyc(21); chk("nom_next_sync", seg, 1);

    // Mid-run config changes must not take effect without a relatch
    wait_cyc(25);
    tseg1 = 5'd7; brp = 8'd3;

    // Positive resync: seg_cnt=0, then seg_cnt=3 (clamped)
    pulse_edge(39, 1'b0);
    pulse_edge(63, 1'b0);
    // Negative resync: seg_cnt=1 skips SYNC
    pulse_edge(87, 1'b0);
    wait_cyc(88); chk("skip_last_tseg2", seg, 3);
    wait_cyc(89); chk("skip_to_tseg1", seg, 2);
    // seg_cnt=0 shrinks TSEG2 to 1 tq
    pulse_edge(97, 1'b0);
    wait_cyc(99); chk("shrink_sync", seg, 1);
    // Second edge in one bit is ignored
    pulse_edge(101, 1'b0);
    pulse_edge(113, 1'b0);
    wait_cyc(116); chk("second_edge_ignored", seg, 3);

    wait_cyc(120);
    tseg1 = 5'd3; brp = 8'd1;
    // Hard sync with a coincident edge
    pulse_edge(130, 1'b1);
    chk("hs_seg", seg, 2);
    chk("hs_tick_p0", tq_tick, 0);
    wait_cyc(132); chk("hs_tick_p1", tq_tick, 1);

    // Drop enable mid-TSEG1
    wait_cyc(150);
    en = 1'b0;
    wait_cyc(151);
    chk("dis_seg", seg, 0);
    chk("dis_tick", tq_tick, 0);
    wait_cyc(160);
    chk("phaseB_bs_left", bs_q.size(), 0);
    chk("phaseB_smp_left", smp_q.size(), 0);

    // Illegal config: sjw > tseg2
    sjw = 2'd3; tseg2 = 4'd1; en = 1'b1;
    wait_cyc(161);
    chk("err_flag", cfg_err, 1);
    chk("err_seg", seg, 0);
    chk("err_tick", tq_tick, 0);
    wait_cyc(165);
    chk("err_hold_seg", seg, 0);
    sjw = 2'd0;
    bs_q.push_back(166);
    wait_cyc(166);
    chk("fix_seg", seg, 1);
    chk("fix_err_clr", cfg_err, 0);

    // Asynchronous reset mid-bit while a tick is active
    wait_cyc(171);
    chk("pre_rst_tick", tq_tick, 1);
    #2;
    rst_n = 1'b0; en = 1'b0;
    #1;
    chk("arst_seg", seg, 0);
    chk("arst_tick", tq_tick, 0);
    chk("arst_bit_start", bit_start, 0);
    chk("arst_cfg_err", cfg_err, 0);

    // brp=0 with maximum segment lengths
    wait_cyc(174);
    rst_n = 1'b1;
    brp = 8'd0; tseg1 = 5'd31; tseg2 = 4'd15; sjw = 2'd3;
    bs_q.push_back(177); bs_q.push_back(226); bs_q.push_back(275);
    smp_q.push_back(209); smp_q.push_back(258);
    wait_cyc(176);
    en = 1'b1;
    wait_cyc(177); chk("max_sync", seg, 1); chk("max_tick", tq_tick, 1);
    wait_cyc(178); chk("max_tseg1", seg, 2);
    wait_cyc(210); chk("max_tseg2", seg, 3);
    wait_cyc(225); chk("max_tseg2_end", seg, 3);
    wait_cyc(226); chk("max_sync2", seg, 1);
    wait_cyc(276);
    en = 1'b0;
    wait_cyc(285);
    chk("end_bs_left", bs_q.size(), 0);
    chk("end_smp_left", smp_q.size(), 0);
    chk("end_seg", seg, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/can_bit_timing.md
Name: can_bit_timing

Overview:
- Parametrised CAN bit-timing generator, the successor to the fixed-divisor CAN clock divider.
- Derives the time quantum (tq) from a runtime prescaler and sequences SYNC/TSEG1/TSEG2 segments from runtime configuration.
- Emits tq ticks, a sample-point pulse and a bit-start pulse.
- Applies CAN hard synchronisation and SJW-limited resynchronisation from an external edge detector. Sits between the system clock and the CAN bit stream processor.

Parameters:
BRP_W, 8, width of prescaler config; tq = brp_i+1 clocks
TSEG1_W, 5, width of tseg1_i; TSEG1 = tseg1_i+1 tq
TSEG2_W, 4, width of tseg2_i; TSEG2 = tseg2_i+1 tq
SJW_W, 2, width of sjw_i; SJW = sjw_i+1 tq

Ports:
clock_in_i  in  1  system clock
reset_ni  in  1  reset, asynchronous, active-low
en_i  in  1  run enable; low forces IDLE synchronously
brp_i  in  BRP_W  prescaler minus 1
tseg1_i  in  TSEG1_W  prop+phase1 length minus 1 (tq)
tseg2_i  in  TSEG2_W  phase2 length minus 1 (tq)
sjw_i  in  SJW_W  sync jump width minus 1 (tq)
hard_sync_i  in  1  one-clock pulse: hard sync on this edge
rx_edge_i  in  1  one-clock pulse: recessive-to-dominant edge (resync candidate)
tq_tick_o  out  1  one-clock pulse on last clock of each tq
sample_pulse_o  out  1  one-clock pulse at sample point (last clock of TSEG1)
bit_start_o  out  1  one-clock pulse on first clock of each bit
seg_o  out  2  0=IDLE 1=SYNC 2=TSEG1 3=TSEG2
cfg_err_o  out  1  configuration rejected

Behaviour:
- Async reset (reset_ni low): state IDLE, all counters 0, all outputs 0, seg_o=0.
- Clocking: only one clock (clock_in_i). Clock period is measured in clock_in_i cycles.
- Config latch: brp/tseg1/tseg2/sjw latched on IDLE->SYNC and on every hard sync. Mid-bit input changes are ignored.
- Config validity check: latch is legal only if sjw_i <= tseg2_i.
  - If illegal: cfg_err_o=1 (registered) and the block stays IDLE.
  - cfg_err_o clears on the next legal start attempt or when en_i=0.
- Start-up: IDLE with en_i=1 and legal config -> next clock is SYNC, pre_cnt=0, bit_start_o=1.
- Prescaler (pre_cnt): counts 0..brp_q.
  - tq_tick_o = running && pre_cnt==brp_q.
  - brp_i=0 gives a tick every clock.
- Segment counter (seg_cnt): counts tq within a segment; advances only on tq_tick and resets to 0 on every segment change.
- SYNC: lasts 1 tq, then TSEG1.
- TSEG1: lasts tseg1_q+1+ext tq.
  - On the final tick: sample_pulse_o=1 (coincident with tq_tick_o), then TSEG2.
- TSEG2: lasts tseg2_q+1−shrink tq, then SYNC.
  - bit_start_o=1 on the first SYNC clock.
- Resync: at most one per bit; flag cleared at each bit start.
  - rx_edge_i in SYNC: ignored, and consumes the flag.
  - rx_edge_i in TSEG1: e=seg_cnt+1; ext=min(e, sjw_q+1).
  - rx_edge_i in TSEG2, with r=tseg2_q+1−seg_cnt:
    - if r<=sjw_q+1: the bit ends at the next tq_tick and the FSM goes straight to TSEG1, skipping SYNC. bit_start_o pulses on the first TSEG1 clock; the edge tq serves as SYNC.
    - else: shrink=sjw_q+1.
  - Resync acts only on segment boundaries; pre_cnt is never disturbed.
- Hard sync: hard_sync_i=1 while running wins over rx_edge_i.
  - Next clock: seg_o=TSEG1, pre_cnt=0, seg_cnt=0, ext=shrink=0, resync flag cleared, config relatched, bit_start_o=1.
  - Ignored in IDLE.
- en_i=0 mid-bit: next clock is IDLE with counters and pulses 0. No partial-bit pulses are emitted afterwards.
- Width rule: ext and shrink are held in registers of width TSEG2_W+1. TSEG1 length arithmetic is done in TSEG1_W+1 bits, so no overflow at maximum config.

Test Plan:
- Nominal timing: brp=1, tseg1=3, tseg2=2, sjw=1, en_i raised at clk0 -> SYNC clk1–2, TSEG1 clk3–10, sample_pulse_o at clk10, TSEG2 clk11–16, bit_start_o at clk1/17/33. Period is 16 clocks; tq_tick_o every 2nd clock.
- Positive resync: same config, rx_edge_i during TSEG1 with seg_cnt=0 -> bit lengthens to 18 clocks. With seg_cnt=3 -> e=4 is clamped to 2, bit lengthens to 20 clocks, and sample_pulse_o moves 4 clocks later.
- Negative resync:
  - rx_edge_i in TSEG2 at seg_cnt=1 (r=2) -> next tq_tick enters TSEG1 directly and bit_start_o pulses with no SYNC state.
  - At seg_cnt=0 (r=3) -> TSEG2 shrinks to 1 tq.
  - A second edge in the same bit is ignored.
- Hard sync: hard_sync_i mid-TSEG2 with rx_edge_i also high -> next clock seg_o=2, pre_cnt=0, bit_start_o=1; the following sample point is exactly 8 clocks later.
- Config error / enable: sjw=3, tseg2=1 with en_i=1 -> cfg_err_o=1, seg_o stays 0, no ticks. Then fix sjw=0 -> starts at SYNC. Dropping en_i mid-TSEG1 -> IDLE next clock with all pulses 0.
- Reset and corners: reset_ni low mid-bit -> all outputs 0 immediately (asynchronously). Also run brp=0 with tseg1/tseg2 at maximum -> bit = 1+32+16 = 49 clocks, no wrap.
